// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder:
// FSM state, the four quadrature levels and the transition classifier.
package quad_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    ARMED = 1'b1
  } quad_state_e;

  localparam logic [1:0] GRAY_00 = 2'b00;
  localparam logic [1:0] GRAY_01 = 2'b01;
  localparam logic [1:0] GRAY_11 = 2'b11;
  localparam logic [1:0] GRAY_10 = 2'b10;

  typedef struct packed {
    logic fwd;
    logic rev;
    logic illegal;
  } quad_dir_t;

  // {A,B} forward order is 00 -> 01 -> 11 -> 10 -> 00; a double-bit change is illegal.
  function automatic quad_dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    quad_dir_t r;
    r = '0;
    case ({prev, cur})
      {GRAY_00, GRAY_01}, {GRAY_01, GRAY_11},
      {GRAY_11, GRAY_10}, {GRAY_10, GRAY_00}: r.fwd = 1'b1;
      {GRAY_01, GRAY_00}, {GRAY_11, GRAY_01},
      {GRAY_10, GRAY_11}, {GRAY_00, GRAY_10}: r.rev = 1'b1;
      default: r.illegal = ((prev ^ cur) == 2'b11);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Quadrature encoder inputs and step/error outputs of the decoder.
// master = encoder/counter side, slave = decoder.
interface quadrature_decoder_if;
  logic a_i;
  logic b_i;
  logic clear_err_i;
  logic up_o;
  logic down_o;
  logic err_o;
  logic err_sticky_o;
  logic armed_o;

  modport master (
    output a_i, b_i, clear_err_i,
    input  up_o, down_o, err_o, err_sticky_o, armed_o
  );

  modport slave (
    input  a_i, b_i, clear_err_i,
    output up_o, down_o, err_o, err_sticky_o, armed_o
  );
endinterface

// File: rtl/glitch_filter.sv
// One quadrature channel: a plain flop synchroniser followed by a stability filter
// that only moves the output level after filter_cycles_p consecutive differing cycles.
module glitch_filter #(
  parameter int sync_stages_p   = 2,
  parameter int filter_cycles_p = 4,
  parameter int filt_width_p    = $clog2(filter_cycles_p + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [filt_width_p-1:0] CNT_LAST = filt_width_p'(filter_cycles_p - 1);

  if (filt_width_p != $clog2(filter_cycles_p + 1)) begin : g_bad_width
    $error("glitch_filter: filt_width_p is derived from filter_cycles_p and must not be overridden");
  end

  logic [sync_stages_p-1:0] sync_q, sync_d;
  logic                     sync_lvl;
  logic                     level_q, level_d;
  logic [filt_width_p-1:0]  cnt_q, cnt_d;

  assign sync_lvl = sync_q[sync_stages_p-1];
  assign level_o  = level_q;

  always_comb begin
    sync_d  = {sync_q[sync_stages_p-2:0], raw_i};
    level_d = level_q;
    cnt_d   = '0;
    if (load_i) begin
      level_d = sync_lvl;
    end else if (sync_lvl != level_q) begin
      // The cycle that completes the run both adopts the new level and restarts the count.
      if (cnt_q == CNT_LAST) begin
        level_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronise and filter both channels, decode Gray transitions
// into registered up/down step pulses (optionally divided) plus illegal-transition flags.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int sync_stages_p    = 2,
  parameter int filter_cycles_p  = 4,
  parameter int steps_per_edge_p = 4,
  parameter int filt_width_p     = $clog2(filter_cycles_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  quadrature_decoder_if.slave qd
);

  localparam int INIT_LEN = sync_stages_p + filter_cycles_p;
  localparam int INIT_W   = $clog2(INIT_LEN + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

  if (sync_stages_p < 2 || sync_stages_p > 4) begin : g_bad_sync
    $error("quadrature_decoder: sync_stages_p must be in 2..4");
  end
  if (filter_cycles_p < 1) begin : g_bad_filter
    $error("quadrature_decoder: filter_cycles_p must be >= 1");
  end
  if (steps_per_edge_p != 1 && steps_per_edge_p != 2 && steps_per_edge_p != 4) begin : g_bad_steps
    $error("quadrature_decoder: steps_per_edge_p must be 1, 2 or 4");
  end
  if (filt_width_p != $clog2(filter_cycles_p + 1)) begin : g_bad_width
    $error("quadrature_decoder: filt_width_p is derived and must not be overridden");
  end

  // Which edges survive the step divider, judged by the level being entered.
  function automatic logic step_kept(input logic [1:0] cur);
    case (steps_per_edge_p)
      4:       return 1'b1;
      2:       return (cur == GRAY_00) || (cur == GRAY_11);
      default: return (cur == GRAY_00);
    endcase
  endfunction

  quad_state_e       state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]        prev_q, prev_d;
  logic              up_q, up_d;
  logic              down_q, down_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic              a_filt, b_filt;
  logic              load;
  logic [1:0]        cur;
  quad_dir_t         dir;

  assign load = (state_q == INIT);
  assign cur  = {a_filt, b_filt};

  glitch_filter #(
    .sync_stages_p  (sync_stages_p),
    .filter_cycles_p(filter_cycles_p),
    .filt_width_p   (filt_width_p)
  ) u_filt_a (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (load),
    .raw_i  (qd.a_i),
    .level_o(a_filt)
  );

  glitch_filter #(
    .sync_stages_p  (sync_stages_p),
    .filter_cycles_p(filter_cycles_p),
    .filt_width_p   (filt_width_p)
  ) u_filt_b (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (load),
    .raw_i  (qd.b_i),
    .level_o(b_filt)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = cur;
    up_d       = 1'b0;
    down_d     = 1'b0;
    err_d      = 1'b0;
    dir        = quad_dir(prev_q, cur);
    case (state_q)
      INIT: begin
        // Let the synchroniser and filter fill with real levels before decoding.
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        up_d   = dir.fwd & step_kept(cur);
        down_d = dir.rev & step_kept(cur);
        err_d  = dir.illegal;
      end
      default: state_d = INIT;
    endcase
    sticky_d = err_d | (sticky_q & ~qd.clear_err_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      prev_q     <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      up_q       <= up_d;
      down_q     <= down_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign qd.up_o         = up_q;
  assign qd.down_o       = down_q;
  assign qd.err_o        = err_q;
  assign qd.err_sticky_o = sticky_q;
  assign qd.armed_o      = (state_q == ARMED);

endmodule
